// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared definitions for the multi-client SRAM controller: FSM states,
// default geometry and the idle value of the read-data register.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_CLIENTS = 2;
  localparam int unsigned DEF_AW          = 20;
  localparam int unsigned DEF_DW          = 16;
  localparam int unsigned DEF_BLW         = 4;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  localparam logic [15:0] DATA_IDLE = 16'h0000;

  // Width of a client index; a single client still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from
// ptr+1 with wrap. The pointer register is owned by the caller.
module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_CLIENTS
) (
  input  logic [N-1:0]                req,
  input  logic [idx_width(N)-1:0]     ptr,
  output logic [N-1:0]                gnt,
  output logic [idx_width(N)-1:0]     idx
);

  localparam int unsigned IW = idx_width(N);

  always_comb begin
    int unsigned pos;
    logic        found;
    gnt   = '0;
    idx   = '0;
    pos   = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Shared external SRAM controller: round-robin arbitration between clients,
// burst reads, single-word writes, programmable access wait cycles.
module sram_arbiter_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned BLW         = DEF_BLW,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_CLIENTS-1:0]     req,
  input  logic [NUM_CLIENTS-1:0]     wr,
  input  logic [NUM_CLIENTS*AW-1:0]  addr_req,
  input  logic [NUM_CLIENTS*DW-1:0]  wdata_req,
  input  logic [NUM_CLIENTS*BLW-1:0] blen_req,
  output logic [NUM_CLIENTS-1:0]     grant,
  output logic [NUM_CLIENTS-1:0]     rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic [NUM_CLIENTS-1:0]     done,
  output logic                       CE,
  output logic                       UB,
  output logic                       LB,
  output logic                       OE,
  output logic                       WE,
  output logic [AW-1:0]              ADDR,
  inout  wire  [DW-1:0]              Data
);

  localparam int unsigned IW = idx_width(NUM_CLIENTS);

  state_t                 state;
  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic [IW-1:0]          ptr;
  logic [DW-1:0]          wdata_q;
  logic [BLW-1:0]         cnt;
  logic                   wr_q;
  logic [2:0]             wait_cnt;
  logic                   ce_n;
  logic                   last_wait;
  logic                   drive_data;

  rr_arbiter #(
    .N (NUM_CLIENTS)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign last_wait = (wait_cnt == 3'(WAIT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      grant    <= '0;
      rd_valid <= '0;
      rd_data  <= DW'(DATA_IDLE);
      ADDR     <= '0;
      ptr      <= IW'(NUM_CLIENTS - 1);
      wdata_q  <= '0;
      cnt      <= '0;
      wr_q     <= 1'b0;
      wait_cnt <= '0;
      ce_n     <= 1'b1;
    end else begin
      ce_n     <= 1'b0;
      rd_valid <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant   <= arb_gnt;
            ptr     <= arb_idx;
            ADDR    <= addr_req[arb_idx*AW +: AW];
            wdata_q <= wdata_req[arb_idx*DW +: DW];
            wr_q    <= wr[arb_idx];
            // Writes are always a single word regardless of the blen field.
            cnt     <= wr[arb_idx] ? '0 : blen_req[arb_idx*BLW +: BLW];
            state   <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (!last_wait) begin
            wait_cnt <= wait_cnt + 3'd1;
          end else begin
            wait_cnt <= '0;
            if (!wr_q) begin
              rd_data  <= Data;
              rd_valid <= grant;
              ADDR     <= ADDR + AW'(1);
            end
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - BLW'(1);
          end
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from registered state; the write strobe rises one
  // cycle early so data is still held on the bus at the WE rising edge.
  assign OE         = !(state == ACCESS && !wr_q);
  assign WE         = !(state == ACCESS && wr_q && !last_wait);
  assign CE         = ce_n;
  assign UB         = ce_n;
  assign LB         = ce_n;
  assign done       = (state == DONE) ? grant : '0;
  assign drive_data = wr_q && (state == SETUP || state == ACCESS);
  assign Data       = drive_data ? wdata_q : 'z;

endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Shared external SRAM controller; successor to the single-client, read-only SRAM reader.
- Serves NUM_CLIENTS requesters (draw engine, sprite loader, game-state logger) using round-robin arbitration.
- Supports burst reads of 1..2^BLW words and single-word writes, with a programmable number of access wait cycles.
- Sits between the client modules and the top-level SRAM pins; owns the bidirectional Data bus.

Parameters:
- NUM_CLIENTS, 2, number of requesting clients (2..8).
- AW, 20, SRAM word-address width.
- DW, 16, SRAM data width.
- BLW, 4, burst-length field width; a burst is blen+1 words.
- WAIT_CYCLES, 2, ACCESS cycles per word (1..7).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-low.
- req  in  NUM_CLIENTS  per-client request level; held high until the matching done pulse.
- wr  in  NUM_CLIENTS  per-client direction: 1=write, 0=read.
- addr_req  in  NUM_CLIENTS*AW  packed start addresses; client i occupies bits [i*AW +: AW].
- wdata_req  in  NUM_CLIENTS*DW  packed write data.
- blen_req  in  NUM_CLIENTS*BLW  packed burst length minus one (reads only).
- grant  out  NUM_CLIENTS  one-hot owner of the current transaction; all zero when idle.
- rd_valid  out  NUM_CLIENTS  one-cycle pulse to the owner; rd_data is valid in that cycle.
- rd_data  out  DW  registered read word.
- done  out  NUM_CLIENTS  one-cycle completion pulse to the owner.
- CE, UB, LB  out  1 each  active-low; 0 except during reset.
- OE, WE  out  1 each  active-low strobes.
- ADDR  out  AW  SRAM address.
- Data  inout  DW  SRAM data bus; high-Z unless writing.

Behaviour:
- Reset (Reset==0 at a Clk edge), effective at that edge even mid-transaction:
  - state=IDLE, grant=0, rd_valid=0, done=0, rd_data=0, ADDR=0.
  - OE=WE=1, CE=UB=LB=1, Data=Z.
  - round-robin pointer = NUM_CLIENTS-1, so client 0 wins first.
- State machine: IDLE -> SETUP -> ACCESS -> (ACCESS for further burst words | DONE) -> IDLE.
- IDLE:
  - If any req is high, the arbiter picks the first requester searching upward from pointer+1, with wrap.
  - At that edge: grant is registered; the winner's addr, wdata, blen and wr are latched; pointer = winner; next state SETUP.
- SETUP (1 cycle):
  - ADDR = latched address; OE=WE=1.
  - If writing, Data is driven with the latched wdata.
- ACCESS (WAIT_CYCLES cycles per word):
  - Read: OE=0.
  - Write: WE=0 except on the final ACCESS cycle, where WE=1 and Data is still driven (data hold).
- End of the final ACCESS cycle of each read word:
  - rd_data <= Data; rd_valid[owner] pulses in the next cycle.
  - ADDR <= ADDR+1, modulo 2^AW (0xFFFFF wraps to 0x00000).
  - Remaining count decrements; if words remain, ACCESS restarts, otherwise next state DONE.
- Writes always transfer exactly one word; blen is ignored.
- DONE (1 cycle):
  - done[owner]=1; OE=WE=1; Data=Z.
  - grant is cleared at the DONE->IDLE edge.
- Timing: back-to-back transactions cost 1 idle cycle between them (DONE -> IDLE -> SETUP).
- Read latency, request seen in cycle 0:
  - First rd_valid in cycle 2+WAIT_CYCLES.
  - Later words every WAIT_CYCLES cycles.
  - done coincides with the last rd_valid.
- req dropping after grant does not abort the transaction; it completes normally.
- req/addr changes during a transaction are ignored until the next IDLE.
- Simultaneous requests: strict round-robin, so no client waits more than NUM_CLIENTS-1 transactions.
- Data bus: Data is never driven while OE=0. The direction change read->write always passes through DONE, IDLE and SETUP.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum {IDLE, SETUP, ACCESS, DONE}.
  - default parameter constants.
  - DATA_IDLE=16'h0000.
- Sub-module rr_arbiter, parameter N:
  - inputs: req, ptr.
  - outputs: one-hot gnt, binary index.
  - purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset values: hold Reset=0 for 3 cycles.
  - -> grant=0, OE=WE=1, Data=Z, rd_data=0.
  - Release, then req[0]=1 read: grant=01 one cycle later.
- Single read: WAIT=2, client0, addr 0x00010, SRAM model returns 0xBEEF.
  - -> OE=0 in cycles 2-3.
  - -> rd_valid[0] and done[0] in cycle 4, rd_data=0xBEEF.
- Burst wrap: client1 read, addr 0xFFFFE, blen=3.
  - -> ADDR sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
  - -> 4 rd_valid[1] pulses 2 cycles apart; done[1] with the 4th.
- Arbitration: req=11 held continuously with single reads.
  - -> grants alternate 01, 10, 01, 10.
  - -> each done pulse is followed by the next grant 2 cycles later.
- Write: client0 writes 0x1234 to 0x00ABC.
  - -> WE=0 in cycle 2 only (WAIT=2); Data=0x1234 in cycles 1-3.
  - -> done[0] in cycle 4; model memory[0xABC]=0x1234.
- Reset mid-burst: assert Reset=0 during the 2nd word of a blen=7 read.
  - -> next edge: all strobes high, Data=Z, grant=0.
  - -> no further rd_valid or done pulses.
